snake_engine: RTL and testbench

//  Game-logic stage upstream of the map memory. It owns the snake body as a circular

---
 rtl/snake_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_snake_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_engine.sv
// Snake game-logic stage: owns the snake body as a circular coordinate buffer,
// clears and paints the map after reset, then advances the snake one cell per tick.
module snake_engine #(
    parameter int unsigned MAPA_WIDTH  = 40,
    parameter int unsigned MAPA_HEIGHT = 30,
    parameter int unsigned MAX_LEN     = 64,
    parameter int unsigned START_X     = 20,
    parameter int unsigned START_Y     = 15,
    parameter int unsigned START_LEN   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] dir_in,
    output logic       update_renable,
    output logic [9:0] update_rx,
    output logic [9:0] update_ry,
    input  logic [1:0] update_rdata,
    output logic       update_wenable,
    output logic [9:0] update_wx,
    output logic [9:0] update_wy,
    output logic [1:0] update_wdata,
    output logic       fruit_eaten,
    output logic       game_over,
    output logic [6:0] length,
    output logic       busy
);

    localparam int unsigned CW = 10;
    localparam int unsigned LW = 7;
    localparam int unsigned PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] X_MAX    = CW'(MAPA_WIDTH - 1);
    localparam logic [CW-1:0] Y_MAX    = CW'(MAPA_HEIGHT - 1);
    localparam logic [CW-1:0] PAINT_X0 = CW'(START_X + 1 - START_LEN);
    localparam logic [CW-1:0] PAINT_N  = CW'(START_LEN);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SNAKE = 2'b01;
    localparam logic [1:0] CELL_FRUIT = 2'b10;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_PAINT,
        S_IDLE,
        S_READ,
        S_DECIDE,
        S_WRITE_HEAD,
        S_ERASE_TAIL,
        S_DEAD
    } state_t;

    state_t          state;
    logic [1:0]      cur_dir;
    logic [CW-1:0]   head_x, head_y;
    logic [CW-1:0]   next_x, next_y;
    logic [CW-1:0]   clr_x, clr_y;
    logic [CW-1:0]   paint_k;
    logic [PW-1:0]   hd_ptr, tl_ptr;
    logic            grow;

    logic [2*CW-1:0] body [MAX_LEN];

    logic [1:0]      sel_dir_c;
    logic [CW-1:0]   step_x_c, step_y_c;
    logic            push_c;
    logic [2*CW-1:0] push_data_c;
    logic [2*CW-1:0] tail_c;
    logic            fruit_ok_c;

    // Direction filter (reverse request keeps current heading) and wrapped next head.
    always_comb begin
        sel_dir_c = dir_in;
        if (dir_in == (cur_dir ^ 2'b10)) begin
            sel_dir_c = cur_dir;
        end
        step_x_c = head_x;
        step_y_c = head_y;
        case (sel_dir_c)
            2'b00:   step_y_c = (head_y == '0)    ? Y_MAX : head_y - CW'(1);
            2'b01:   step_x_c = (head_x == X_MAX) ? '0    : head_x + CW'(1);
            2'b10:   step_y_c = (head_y == Y_MAX) ? '0    : head_y + CW'(1);
            default: step_x_c = (head_x == '0)    ? X_MAX : head_x - CW'(1);
        endcase
    end

    always_comb begin
        push_c      = ((state == S_PAINT) && (paint_k != PAINT_N)) || (state == S_WRITE_HEAD);
        push_data_c = (state == S_PAINT) ? {PAINT_X0 + paint_k, CW'(START_Y)} : {next_x, next_y};
        tail_c      = body[tl_ptr];
        fruit_ok_c  = (update_rdata == CELL_FRUIT) && (length != LW'(MAX_LEN));
    end

    // Body buffer storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_c) begin
            body[hd_ptr] <= push_data_c;
        end
    end

    // Main sequencer: outputs are registered together with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_CLEAR;
            cur_dir        <= 2'b01;
            head_x         <= '0;
            head_y         <= '0;
            next_x         <= '0;
            next_y         <= '0;
            clr_x          <= '0;
            clr_y          <= '0;
            paint_k        <= '0;
            hd_ptr         <= '0;
            tl_ptr         <= '0;
            grow           <= 1'b0;
            update_renable <= 1'b0;
            update_rx      <= '0;
            update_ry      <= '0;
            update_wenable <= 1'b0;
            update_wx      <= '0;
            update_wy      <= '0;
            update_wdata   <= '0;
            fruit_eaten    <= 1'b0;
            game_over      <= 1'b0;
            length         <= '0;
            busy           <= 1'b1;
        end else begin
            update_renable <= 1'b0;
            update_wenable <= 1'b0;
            fruit_eaten    <= 1'b0;
            case (state)
                S_CLEAR: begin
                    update_wenable <= 1'b1;
                    update_wx      <= clr_x;
                    update_wy      <= clr_y;
                    update_wdata   <= CELL_EMPTY;
                    if (clr_x == X_MAX) begin
                        clr_x <= '0;
                        if (clr_y == Y_MAX) begin
                            state <= S_PAINT;
                        end else begin
                            clr_y <= clr_y + CW'(1);
                        end
                    end else begin
                        clr_x <= clr_x + CW'(1);
                    end
                end
                S_PAINT: begin
                    if (paint_k == PAINT_N) begin
                        length <= LW'(START_LEN);
                        head_x <= CW'(START_X);
                        head_y <= CW'(START_Y);
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        update_wenable <= 1'b1;
                        update_wx      <= PAINT_X0 + paint_k;
                        update_wy      <= CW'(START_Y);
                        update_wdata   <= CELL_SNAKE;
                        paint_k        <= paint_k + CW'(1);
                        hd_ptr         <= hd_ptr + PW'(1);
                    end
                end
                S_IDLE: begin
                    if (tick) begin
                        cur_dir        <= sel_dir_c;
                        next_x         <= step_x_c;
                        next_y         <= step_y_c;
                        update_renable <= 1'b1;
                        update_rx      <= step_x_c;
                        update_ry      <= step_y_c;
                        busy           <= 1'b1;
                        state          <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_DECIDE;
                end
                S_DECIDE: begin
                    // Codes 01 (snake, including current tail) and 11 (obstacle) are fatal.
                    if (update_rdata[0]) begin
                        game_over <= 1'b1;
                        state     <= S_DEAD;
                    end else begin
                        grow           <= fruit_ok_c;
                        fruit_eaten    <= fruit_ok_c;
                        update_wenable <= 1'b1;
                        update_wx      <= next_x;
                        update_wy      <= next_y;
                        update_wdata   <= CELL_SNAKE;
                        state          <= S_WRITE_HEAD;
                    end
                end
                S_WRITE_HEAD: begin
                    hd_ptr <= hd_ptr + PW'(1);
                    head_x <= next_x;
                    head_y <= next_y;
                    if (grow) begin
                        length <= length + LW'(1);
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        update_wenable <= 1'b1;
                        update_wx      <= tail_c[2*CW-1:CW];
                        update_wy      <= tail_c[CW-1:0];
                        update_wdata   <= CELL_EMPTY;
                        state          <= S_ERASE_TAIL;
                    end
                end
                S_ERASE_TAIL: begin
                    tl_ptr <= tl_ptr + PW'(1);
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_DEAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// Directed self-checking bench for snake_engine: init sequence, moves, wrap, fruit,
// direction filtering, death and reset during a step.
module tb_snake_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] dir_in;
    logic       update_renable;
    logic [9:0] update_rx, update_ry;
    logic [1:0] update_rdata;
    logic       update_wenable;
    logic [9:0] update_wx, update_wy;
    logic [1:0] update_wdata;
    logic       fruit_eaten;
    logic       game_over;
    logic [6:0] length;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    snake_engine dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .dir_in         (dir_in),
        .update_renable (update_renable),
        .update_rx      (update_rx),
        .update_ry      (update_ry),
        .update_rdata   (update_rdata),
        .update_wenable (update_wenable),
        .update_wx      (update_wx),
        .update_wy      (update_wy),
        .update_wdata   (update_wdata),
        .fruit_eaten    (fruit_eaten),
        .game_over      (game_over),
        .length         (length),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) break;
            cyc();
        end
        check("idle_wait", 32'(busy), 32'(0));
    endtask

    // One game step; tick is high during cycle T, sampling at T+1..T+5.
    task automatic do_step(input logic [1:0] d, input logic [1:0] rd, input int ex, input int ey,
                           input logic exp_fruit, input int tx, input int ty);
        dir_in       = d;
        update_rdata = rd;
        tick         = 1'b1;
        cyc();
        tick = 1'b0;
        check("rd_en", 32'(update_renable), 32'(1));
        check("rd_x", 32'(update_rx), 32'(ex));
        check("rd_y", 32'(update_ry), 32'(ey));
        cyc();
        check("t2_quiet", 32'({update_renable, update_wenable}), 32'(0));
        cyc();
        check("hd_wen", 32'(update_wenable), 32'(1));
        check("hd_x", 32'(update_wx), 32'(ex));
        check("hd_y", 32'(update_wy), 32'(ey));
        check("hd_data", 32'(update_wdata), 32'(1));
        check("fruit", 32'(fruit_eaten), 32'(exp_fruit));
        cyc();
        check("fruit_end", 32'(fruit_eaten), 32'(0));
        if (exp_fruit) begin
            check("no_erase", 32'(update_wenable), 32'(0));
        end else begin
            check("tl_wen", 32'(update_wenable), 32'(1));
            check("tl_x", 32'(update_wx), 32'(tx));
            check("tl_y", 32'(update_wy), 32'(ty));
            check("tl_data", 32'(update_wdata), 32'(0));
            cyc();
        end
        check("busy_low", 32'(busy), 32'(0));
    endtask

    initial begin
        int bad;
        reset        = 1'b1;
        tick         = 1'b0;
        dir_in       = 2'b01;
        update_rdata = 2'b00;
        repeat (3) cyc();

        check("rst_busy", 32'(busy), 32'(1));
        check("rst_wen", 32'(update_wenable), 32'(0));
        check("rst_ren", 32'(update_renable), 32'(0));
        check("rst_over", 32'(game_over), 32'(0));
        check("rst_len", 32'(length), 32'(0));
        check("rst_fruit", 32'(fruit_eaten), 32'(0));
        reset = 1'b0;

        // Map clear: 1200 writes of 00, row-major with x fastest.
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (update_wenable === 1'b1) break;
        end
        check("first_clear", 32'(update_wenable), 32'(1));
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            if (!(update_wenable === 1'b1 && update_renable === 1'b0 &&
                  32'(update_wx) == 32'(i % 40) && 32'(update_wy) == 32'(i / 40) &&
                  update_wdata === 2'b00))
                bad++;
            cyc();
        end
        check("clear_seq", 32'(bad), 32'(0));

        // Initial snake painted tail first.
        for (int k = 0; k < 3; k++) begin
            check("paint_wen", 32'(update_wenable), 32'(1));
            check("paint_x", 32'(update_wx), 32'(18 + k));
            check("paint_y", 32'(update_wy), 32'(15));
            check("paint_data", 32'(update_wdata), 32'(1));
            check("paint_busy", 32'(busy), 32'(1));
            cyc();
        end
        check("init_busy", 32'(busy), 32'(0));
        check("init_wen", 32'(update_wenable), 32'(0));
        check("init_len", 32'(length), 32'(3));

        // Plain move right, then walk to the right edge.
        do_step(2'b01, 2'b00, 21, 15, 1'b0, 18, 15);
        for (int h = 22; h < 40; h++) begin
            do_step(2'b01, 2'b00, h, 15, 1'b0, h - 3, 15);
        end

        // Wrap to column 0 onto fruit: grows, no erase.
        do_step(2'b01, 2'b10, 0, 15, 1'b1, 0, 0);
        check("len_grow", 32'(length), 32'(4));

        // Reverse request ignored, then turn up.
        do_step(2'b11, 2'b00, 1, 15, 1'b0, 37, 15);
        do_step(2'b00, 2'b00, 1, 14, 1'b0, 38, 15);
        check("len_keep", 32'(length), 32'(4));

        // Obstacle ahead: game over, nothing written, ticks ignored.
        dir_in       = 2'b00;
        update_rdata = 2'b11;
        tick         = 1'b1;
        cyc();
        tick = 1'b0;
        check("dead_rd_y", 32'(update_ry), 32'(13));
        cyc();
        cyc();
        check("dead_over", 32'(game_over), 32'(1));
        check("dead_wen", 32'(update_wenable), 32'(0));
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick = (i % 3 == 0);
            cyc();
            if (update_wenable !== 1'b0 || update_renable !== 1'b0) bad++;
        end
        tick = 1'b0;
        check("dead_quiet", 32'(bad), 32'(0));
        check("dead_busy", 32'(busy), 32'(1));
        check("dead_len", 32'(length), 32'(4));
        reset = 1'b1;
        #1;
        check("rst2_over", 32'(game_over), 32'(0));
        check("rst2_len", 32'(length), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        update_rdata = 2'b00;
        wait_idle(1400);
        check("rst2_init_len", 32'(length), 32'(3));

        // Reset asserted while the head write is on the bus.
        dir_in = 2'b01;
        tick   = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        check("mid_wen", 32'(update_wenable), 32'(1));
        check("mid_x", 32'(update_wx), 32'(21));
        #2;
        reset = 1'b1;
        #1;
        check("abort_wen", 32'(update_wenable), 32'(0));
        check("abort_busy", 32'(busy), 32'(1));
        @(negedge clk);
        reset = 1'b0;
        cyc();
        check("restart_wen", 32'(update_wenable), 32'(1));
        check("restart_x", 32'(update_wx), 32'(0));
        check("restart_y", 32'(update_wy), 32'(0));
        check("restart_data", 32'(update_wdata), 32'(0));
        wait_idle(1400);
        check("restart_len", 32'(length), 32'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
